// File: rtl/matmul_seq_if.sv
// rtl/matmul_seq_if.sv - operand memory read ports and result sink port of matmul_seq
interface matmul_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 5,
    parameter int ACC_W      = 37
);
    logic                         a_rd_en;
    logic [IDX_W-1:0]             a_row;
    logic [IDX_W-1:0]             a_col;
    logic signed [DATA_WIDTH-1:0] a_rdata;
    logic                         b_rd_en;
    logic [IDX_W-1:0]             b_row;
    logic [IDX_W-1:0]             b_col;
    logic signed [DATA_WIDTH-1:0] b_rdata;
    logic                         c_wr_en;
    logic [IDX_W-1:0]             c_row;
    logic [IDX_W-1:0]             c_col;
    logic signed [ACC_W-1:0]      c_wdata;
    logic                         c_ready;

    modport master (
        output a_rd_en, a_row, a_col, b_rd_en, b_row, b_col,
        output c_wr_en, c_row, c_col, c_wdata,
        input  a_rdata, b_rdata, c_ready
    );

    modport slave (
        input  a_rd_en, a_row, a_col, b_rd_en, b_row, b_col,
        input  c_wr_en, c_row, c_col, c_wdata,
        output a_rdata, b_rdata, c_ready
    );
endinterface

// File: rtl/matmul_seq.sv
// rtl/matmul_seq.sv - sequential signed matrix multiply controller, one MAC lane time-shared over C
module matmul_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 32,
    parameter int DIM_W      = $clog2(M) + 1,
    parameter int IDX_W      = $clog2(M),
    parameter int ACC_W      = 2 * DATA_WIDTH + $clog2(M)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIM_W-1:0] rows,
    input  logic [DIM_W-1:0] cols,
    input  logic [DIM_W-1:0] cols2,
    output logic             busy,
    output logic             done,
    output logic             err,
    matmul_seq_if.master     mem
);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, FIN} state_t;

    localparam logic [DIM_W-1:0] MAX_DIM = DIM_W'(M);
    localparam logic [DIM_W-1:0] ONE     = DIM_W'(1);

    state_t                       state;
    logic [DIM_W-1:0]             n_lat, m_lat, q_lat;
    logic [IDX_W-1:0]             i, j, k;
    logic                         rd_en;
    logic                         wr_en;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      wdata;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]      acc_next;
    logic                         illegal;
    logic                         last_k, last_i, last_j;

    assign illegal = (rows == '0) || (cols == '0) || (cols2 == '0) ||
                     (rows > MAX_DIM) || (cols > MAX_DIM) || (cols2 > MAX_DIM);

    // Operand data always belongs to the reads issued in the previous cycle.
    assign prod     = mem.a_rdata * mem.b_rdata;
    assign acc_next = acc + {{(ACC_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

    assign last_k = (DIM_W'(k) == m_lat - ONE);
    assign last_i = (DIM_W'(i) == n_lat - ONE);
    assign last_j = (DIM_W'(j) == q_lat - ONE);

    assign mem.a_rd_en = rd_en;
    assign mem.b_rd_en = rd_en;
    assign mem.a_row   = i;
    assign mem.a_col   = k;
    assign mem.b_row   = k;
    assign mem.b_col   = j;
    assign mem.c_wr_en = wr_en;
    assign mem.c_row   = i;
    assign mem.c_col   = j;
    assign mem.c_wdata = wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            n_lat <= '0;
            m_lat <= '0;
            q_lat <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            rd_en <= 1'b0;
            wr_en <= 1'b0;
            acc   <= '0;
            wdata <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat <= rows;
                        m_lat <= cols;
                        q_lat <= cols2;
                        busy  <= 1'b1;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        if (illegal) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= RUN;
                            rd_en <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc <= (k == '0) ? '0 : acc_next;
                    if (last_k) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    acc   <= acc_next;
                    wdata <= acc_next;
                    wr_en <= 1'b1;
                    state <= WRITE;
                end
                WRITE: begin
                    if (mem.c_ready) begin
                        wr_en <= 1'b0;
                        k     <= '0;
                        if (last_i && last_j) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            if (last_j) begin
                                j <= '0;
                                i <= i + 1'b1;
                            end else begin
                                j <= j + 1'b1;
                            end
                            rd_en <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    i     <= '0;
                    j     <= '0;
                    k     <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_seq.sv
// tb/tb_matmul_seq.sv - directed bench for matmul_seq with a result scoreboard
module tb_matmul_seq;
    localparam int DW    = 16;
    localparam int M     = 32;
    localparam int DIM_W = 6;
    localparam int IDX_W = 5;
    localparam int ACC_W = 37;

    typedef struct {
        int                 row;
        int                 col;
        logic signed [63:0] data;
    } res_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [DIM_W-1:0] rows, cols, cols2;
    logic             busy, done, err;

    matmul_seq_if #(.DATA_WIDTH(DW), .IDX_W(IDX_W), .ACC_W(ACC_W)) mem_if ();

    matmul_seq #(.DATA_WIDTH(DW), .M(M)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .rows  (rows),
        .cols  (cols),
        .cols2 (cols2),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .mem   (mem_if.master)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] a_mem [M][M];
    logic signed [DW-1:0] b_mem [M][M];
    res_t sb[$];

    int  n_checks = 0;
    int  n_errors = 0;
    bit  bp_mode  = 1'b0;
    int  wcnt     = 0;
    int  rda_cnt, rdb_cnt, wr_cnt;
    logic [IDX_W-1:0]        hold_row, hold_col;
    logic signed [ACC_W-1:0] hold_data;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (mem_if.a_rd_en) mem_if.a_rdata <= a_mem[mem_if.a_row][mem_if.a_col];
        if (mem_if.b_rd_en) mem_if.b_rdata <= b_mem[mem_if.b_row][mem_if.b_col];
    end

    // Result sink: decides c_ready for the next edge and scores accepted writes.
    always @(negedge clk) begin
        if (reset || !mem_if.c_wr_en) begin
            mem_if.c_ready = 1'b1;
            wcnt = 0;
        end else begin
            if (!reset && mem_if.a_rd_en) rda_cnt++;
            if (wcnt == 0) begin
                hold_row  = mem_if.c_row;
                hold_col  = mem_if.c_col;
                hold_data = mem_if.c_wdata;
            end else begin
                check("hold_row", 64'(mem_if.c_row), 64'(hold_row));
                check("hold_col", 64'(mem_if.c_col), 64'(hold_col));
                check("hold_data", mem_if.c_wdata, hold_data);
            end
            if (bp_mode && wcnt < 2) begin
                mem_if.c_ready = 1'b0;
                wcnt++;
            end else begin
                res_t r;
                mem_if.c_ready = 1'b1;
                wcnt = 0;
                wr_cnt++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    r = sb.pop_front();
                    check("c_row", 64'(mem_if.c_row), 64'(r.row));
                    check("c_col", 64'(mem_if.c_col), 64'(r.col));
                    check("c_wdata", mem_if.c_wdata, r.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && mem_if.a_rd_en && !mem_if.c_wr_en) rda_cnt++;
        if (!reset && mem_if.b_rd_en) rdb_cnt++;
    end

    task automatic push_model(input int n, input int m, input int q);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < q; j++) begin
                res_t r;
                logic signed [63:0] s;
                s = 0;
                for (int kk = 0; kk < m; kk++)
                    s += 64'(a_mem[i][kk]) * 64'(b_mem[kk][j]);
                r.row  = i;
                r.col  = j;
                r.data = s;
                sb.push_back(r);
            end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_strobes"}, 64'({mem_if.a_rd_en, mem_if.b_rd_en, mem_if.c_wr_en}), 64'd0);
        check({tag, "_addr"}, 64'({mem_if.a_row, mem_if.a_col, mem_if.b_row, mem_if.b_col,
                                   mem_if.c_row, mem_if.c_col}), 64'd0);
        check({tag, "_wdata"}, mem_if.c_wdata, 64'd0);
    endtask

    // Called at a negedge; returns at a negedge two cycles after done.
    task automatic run_job(input string tag, input int n, input int m, input int q,
                           input bit bp, input bit bad, input bit hold_start);
        int  exp_t, t;
        bit  got;
        if (!bad) push_model(n, m, q);
        bp_mode = bp;
        rda_cnt = 0;
        rdb_cnt = 0;
        wr_cnt  = 0;
        rows  = DIM_W'(n);
        cols  = DIM_W'(m);
        cols2 = DIM_W'(q);
        start = 1'b1;
        exp_t = bad ? 1 : n * q * (m + 2 + (bp ? 2 : 0)) + 1;
        t   = 0;
        got = 1'b0;
        while (t < exp_t + 100) begin
            @(negedge clk);
            t++;
            if (t == 1) check({tag, "_busy_on"}, 64'(busy), 64'd1);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (t == 1) begin
                start = hold_start;
                rows  = 6'd4;
                cols  = 6'd4;
                cols2 = 6'd4;
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(t), 64'(exp_t));
        check({tag, "_err"}, 64'(err), 64'(bad));
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_busy_off"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_still_idle"}, 64'(busy), 64'd0);
        check({tag, "_a_reads"}, 64'(rda_cnt), bad ? 64'd0 : 64'(n * m * q));
        check({tag, "_b_reads"}, 64'(rdb_cnt), bad ? 64'd0 : 64'(n * m * q));
        check({tag, "_writes"}, 64'(wr_cnt), bad ? 64'd0 : 64'(n * q));
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        sb.delete();
        bp_mode = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        rows  = '0;
        cols  = '0;
        cols2 = '0;
        for (int i = 0; i < M; i++)
            for (int kk = 0; kk < M; kk++) begin
                a_mem[i][kk] = '0;
                b_mem[i][kk] = '0;
            end
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        a_mem[0][0] = 1;  a_mem[0][1] = 2;  a_mem[0][2] = 3;
        a_mem[1][0] = 4;  a_mem[1][1] = 5;  a_mem[1][2] = 6;
        b_mem[0][0] = 7;  b_mem[0][1] = 8;
        b_mem[1][0] = 9;  b_mem[1][1] = 10;
        b_mem[2][0] = 11; b_mem[2][1] = 12;
        run_job("basic_2x3x2", 2, 3, 2, 1'b0, 1'b0, 1'b0);

        a_mem[0][0] = 1;  a_mem[0][1] = -2; a_mem[1][0] = 3;  a_mem[1][1] = 4;
        b_mem[0][0] = 5;  b_mem[0][1] = 6;  b_mem[1][0] = -7; b_mem[1][1] = 8;
        run_job("backpressure", 2, 2, 2, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < M; i++)
            for (int kk = 0; kk < M; kk++) begin
                a_mem[i][kk] = DW'($urandom);
                b_mem[i][kk] = DW'($urandom);
            end
        run_job("random_3x5x4", 3, 5, 4, 1'b0, 1'b0, 1'b0);
        run_job("m_is_one", 3, 1, 2, 1'b0, 1'b0, 1'b0);
        run_job("restart_ignored", 2, 3, 2, 1'b0, 1'b0, 1'b1);

        run_job("illegal_cols0", 2, 0, 2, 1'b0, 1'b1, 1'b0);
        run_job("illegal_rows33", 33, 2, 2, 1'b0, 1'b1, 1'b0);

        // Abort a 4x4x4 job while it is still in its first RUN.
        rows  = 6'd4;
        cols  = 6'd4;
        cols2 = 6'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrun_reset");
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        run_job("after_reset_4x4x4", 4, 4, 4, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < M; i++)
            for (int kk = 0; kk < M; kk++) begin
                a_mem[i][kk] = -16'sd32768;
                b_mem[i][kk] = -16'sd32768;
            end
        check("extreme_model", 64'(32) * 64'(a_mem[0][0]) * 64'(b_mem[0][0]), 64'd34359738368);
        run_job("extreme_32x32x32", 32, 32, 32, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/matmul_seq.md
Name: matmul_seq

Overview:
- Sequencing controller for the signed matrix-multiply datapath. Computes C = A x B with runtime dimensions (rows x cols) * (cols x cols2), each dimension up to M.
- Drives one signed multiply-accumulate lane, time-shared over all output elements.
- Fetches operands from two external synchronous-read operand memories (A, B) and streams results to a result sink with backpressure.
- Sits between the host/test harness (start/done) and the operand/result storage. Replaces the fully parallel array product where area matters.

Parameters:
- DATA_WIDTH, 16, signed operand element width.
- M, 32, maximum supported dimension.
- DIM_W, $clog2(M)+1, width of dimension inputs (must encode the value M).
- IDX_W, $clog2(M), width of row/column indices.
- ACC_W, 2*DATA_WIDTH+$clog2(M), signed accumulator/result width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a multiply; sampled only in IDLE
- rows  in  DIM_W  rows of A (n)
- cols  in  DIM_W  cols of A = rows of B (m)
- cols2  in  DIM_W  cols of B (q)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, for illegal dimensions
- a_rd_en  out  1  A read strobe
- a_row, a_col  out  IDX_W each  A read address (i, k)
- a_rdata  in  DATA_WIDTH  signed A data, valid the cycle after a_rd_en
- b_rd_en  out  1  B read strobe
- b_row, b_col  out  IDX_W each  B read address (k, j)
- b_rdata  in  DATA_WIDTH  signed B data, valid the cycle after b_rd_en
- c_wr_en  out  1  result valid
- c_row, c_col  out  IDX_W each  result index (i, j)
- c_wdata  out  ACC_W  signed result
- c_ready  in  1  sink accepts the result when c_wr_en && c_ready

Behaviour:
Reset:
- All outputs go to 0 and state goes to IDLE.
- Reset in any state aborts immediately. No further reads or writes, no done.

States: IDLE, RUN, DRAIN, WRITE, FIN.

IDLE:
- On start, latch rows/cols/cols2. Illegal means any dimension is 0 or > M.
- If illegal: go to FIN with err=1.
- If legal: clear i, j, k; go to RUN.
- start in any other state is ignored. Latched dimensions are immune to input changes.

RUN (one cycle per k, k = 0..m-1):
- a_rd_en = b_rd_en = 1, with a=(i,k) and b=(k,j).
- At k=0: acc <= 0.
- At k>=1: acc <= acc + sext(a_rdata)*sext(b_rdata), using the data for k-1.
- After k = m-1: go to DRAIN.

DRAIN (1 cycle):
- No reads issued.
- acc <= acc + product of the k=m-1 data.
- Go to WRITE.

WRITE:
- c_wr_en=1, c_row=i, c_col=j, c_wdata=acc. These are held stable while c_ready=0.
- On handshake, advance in row-major order: j++, wrapping to 0 with i++.
- If (i,j) was the last element (n-1, q-1), go to FIN; else go to RUN with k=0.

FIN (1 cycle):
- done=1 (err=1 if illegal); busy=0 next cycle; return to IDLE.
- A start arriving in the FIN cycle is ignored.

Arithmetic:
- Products are full-precision signed 2*DATA_WIDTH, accumulated in ACC_W.
- No overflow is possible for m <= M; no saturation.

Timing:
- With c_ready held high, elapsed cycles from start acceptance to done = n*q*(m+2)+1.
- m=1 is legal: RUN 1 cycle, DRAIN, WRITE.

Invariants:
- a_rd_en/b_rd_en are never high outside RUN.
- c_wr_en is never high outside WRITE.
- Indices stay below their latched dimensions.

Test Plan:
- 2x3 * 3x2, A=[[1,2,3],[4,5,6]], B=[[7,8],[9,10],[11,12]], c_ready=1 -> writes in order (0,0)=58, (0,1)=64, (1,0)=139, (1,1)=154; done exactly 21 cycles after start; err=0.
- Signed extremes, 32x32x32, all A=-32768, all B=-32768 -> every c_wdata = 32*2^30 = 34359738368 (no wrap in 37 bits); 1024 writes.
- Backpressure: the 2x2*2x2 case with c_ready toggling 0,0,1 per WRITE -> c_wdata/c_row/c_col held stable while stalled, no duplicate or dropped writes, done delayed by 2 cycles per element.
- Illegal dims: cols=0, then rows=33 -> done+err pulse in the cycle after start; zero read/write strobes; busy is high for only that 1 cycle.
- Reset mid-RUN of a 4x4x4 job -> next cycle all outputs 0, state IDLE. A fresh start then produces correct results from (0,0).
- start re-asserted while busy, with dims changed -> ignored; results match the originally latched dimensions.
